// File: rtl/cordic_arbiter.sv
// cordic_arbiter
// Shares one pipelined CORDIC datapath between two requesters. A round-robin
// arbiter grants one angle per cycle. The granted angle is folded into the
// +/-90 degree range and registered onto cordic_angle. A tag (valid, id,
// fold, err) travels alongside the datapath so that the settled cordic_x and
// cordic_y can be routed back to the requester that owns them.
//
// Ports
//   clk                        rising-edge clock
//   reset                      asynchronous, active-low reset
//   req0_valid / req1_valid    requester has an angle pending
//   req0_angle / req1_angle    sign-magnitude degrees: [19] sign, [18:0] magnitude (12 frac bits)
//   req0_ready / req1_ready    grant, combinational from valid and the priority pointer
//   rsp0_valid / rsp1_valid    one-cycle result strobe to the owning requester
//   rsp*_sin / rsp*_cos        sign-magnitude result: [11] sign, [10:0] magnitude (9 frac bits)
//   rsp0_err / rsp1_err        angle was out of range (qualified by rsp*_valid)
//   cordic_angle               registered angle driven to the datapath
//   cordic_x / cordic_y        cosine / sine returned by the datapath
//   busy                       some accepted request has not yet responded
module cordic_arbiter #(
  parameter int LATENCY = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic [19:0] req0_angle,
  input  logic [19:0] req1_angle,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [11:0] rsp0_sin,
  output logic [11:0] rsp0_cos,
  output logic [11:0] rsp1_sin,
  output logic [11:0] rsp1_cos,
  output logic        rsp0_err,
  output logic        rsp1_err,
  output logic [19:0] cordic_angle,
  input  logic [11:0] cordic_x,
  input  logic [11:0] cordic_y,
  output logic        busy
);

  localparam logic [19:0] ANGLE_90  = 20'h5A000;
  localparam logic [19:0] ANGLE_180 = 20'hB4000;

  // Round-robin pointer: 0 gives requester 0 priority on contention.
  logic r_ptr;

  logic w_gnt0;
  logic w_gnt1;
  logic w_fire;
  logic w_gid;

  // A lone valid requester is granted regardless of the pointer.
  assign w_gnt0 = req0_valid & (~r_ptr | ~req1_valid);
  assign w_gnt1 = req1_valid & ( r_ptr | ~req0_valid);

  // Gated by reset so the grants drop the moment reset is asserted.
  assign req0_ready = w_gnt0 & reset;
  assign req1_ready = w_gnt1 & reset;

  assign w_fire = req0_ready | req1_ready;
  assign w_gid  = req1_ready;

  // Range fold of the granted angle.
  logic [19:0] w_angle;
  logic [19:0] w_mag;
  logic [18:0] w_fold_mag;
  logic [19:0] w_folded;
  logic        w_fold;
  logic        w_err;

  assign w_angle    = w_gid ? req1_angle : req0_angle;
  assign w_mag      = {1'b0, w_angle[18:0]};
  assign w_fold_mag = 19'(ANGLE_180 - w_mag);

  // The 19-bit magnitude field tops out just below 128 degrees, so with this
  // encoding the error branch cannot be reached; it is kept so the datapath
  // stays correct should the magnitude field ever be widened.
  always_comb begin
    w_fold   = 1'b0;
    w_err    = 1'b0;
    w_folded = w_angle;
    if (w_mag <= ANGLE_90) begin
      w_folded = w_angle;
    end else if (w_mag <= ANGLE_180) begin
      w_fold   = 1'b1;
      w_folded = {w_angle[19], w_fold_mag};
    end else begin
      w_err    = 1'b1;
    end
  end

  // Tag pipeline. Stage 0 is loaded on acceptance; the response registers
  // form the final stage, so a result appears LATENCY+1 cycles after the
  // grant cycle. The datapath must have settled on the accepted angle by the
  // time the tag leaves stage LATENCY-1.
  logic [LATENCY-1:0] r_tag_valid;
  logic [LATENCY-1:0] r_tag_id;
  logic [LATENCY-1:0] r_tag_fold;
  logic [LATENCY-1:0] r_tag_err;
  logic [19:0]        r_cordic_angle;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr          <= 1'b0;
      r_cordic_angle <= '0;
      r_tag_valid    <= '0;
      r_tag_id       <= '0;
      r_tag_fold     <= '0;
      r_tag_err      <= '0;
    end else begin
      if (w_fire) begin
        r_ptr <= ~w_gid;
      end
      // Error requests leave the datapath angle untouched.
      if (w_fire && !w_err) begin
        r_cordic_angle <= w_folded;
      end
      for (int i = LATENCY - 1; i > 0; i--) begin
        r_tag_valid[i] <= r_tag_valid[i-1];
        r_tag_id[i]    <= r_tag_id[i-1];
        r_tag_fold[i]  <= r_tag_fold[i-1];
        r_tag_err[i]   <= r_tag_err[i-1];
      end
      r_tag_valid[0] <= w_fire;
      r_tag_id[0]    <= w_gid;
      r_tag_fold[0]  <= w_fold;
      r_tag_err[0]   <= w_err;
    end
  end

  logic        w_last_valid;
  logic        w_last_id;
  logic [11:0] w_sin;
  logic [11:0] w_cos;

  assign w_last_valid = r_tag_valid[LATENCY-1];
  assign w_last_id    = r_tag_id[LATENCY-1];
  // Folding maps a to 180-a, which keeps sine and negates cosine.
  assign w_sin = r_tag_err[LATENCY-1] ? 12'h000 : cordic_y;
  assign w_cos = r_tag_err[LATENCY-1] ? 12'h000
               : {cordic_x[11] ^ r_tag_fold[LATENCY-1], cordic_x[10:0]};

  logic        r_rsp0_valid;
  logic        r_rsp1_valid;
  logic [11:0] r_rsp0_sin;
  logic [11:0] r_rsp0_cos;
  logic [11:0] r_rsp1_sin;
  logic [11:0] r_rsp1_cos;
  logic        r_rsp0_err;
  logic        r_rsp1_err;

  // Data registers only load on their own strobe, so they hold otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_sin   <= '0;
      r_rsp0_cos   <= '0;
      r_rsp1_sin   <= '0;
      r_rsp1_cos   <= '0;
      r_rsp0_err   <= 1'b0;
      r_rsp1_err   <= 1'b0;
    end else begin
      r_rsp0_valid <= w_last_valid & ~w_last_id;
      r_rsp1_valid <= w_last_valid &  w_last_id;
      if (w_last_valid && !w_last_id) begin
        r_rsp0_sin <= w_sin;
        r_rsp0_cos <= w_cos;
        r_rsp0_err <= r_tag_err[LATENCY-1];
      end
      if (w_last_valid && w_last_id) begin
        r_rsp1_sin <= w_sin;
        r_rsp1_cos <= w_cos;
        r_rsp1_err <= r_tag_err[LATENCY-1];
      end
    end
  end

  assign rsp0_valid   = r_rsp0_valid;
  assign rsp1_valid   = r_rsp1_valid;
  assign rsp0_sin     = r_rsp0_sin;
  assign rsp0_cos     = r_rsp0_cos;
  assign rsp1_sin     = r_rsp1_sin;
  assign rsp1_cos     = r_rsp1_cos;
  assign rsp0_err     = r_rsp0_err;
  assign rsp1_err     = r_rsp1_err;
  assign cordic_angle = r_cordic_angle;
  assign busy         = (|r_tag_valid) | r_rsp0_valid | r_rsp1_valid;

endmodule
